// File: rtl/uart_program_loader.sv
// uart_program_loader
// Receives a program image over an 8N1 UART line and writes it onto the
// RAM bus, holding the CPU in reset until a frame with a good checksum lands.
// Frame: 0xA5, count N (0 = 256), N data bytes, checksum (sum of data mod 256).
//
// Ports:
//   clock     bus clock, rising edge
//   reset     synchronous active-high reset
//   rx        UART receive line (idles high, asynchronous)
//   address   bus address of the current write
//   write_en  one-cycle write strobe
//   data      bus write data
//   cpu_hold  CPU held in reset / bus owned by loader
//   done      last frame loaded with a good checksum
//   error     last frame failed (checksum or framing)
module uart_program_loader #(
    parameter int unsigned CLKS_PER_BIT = 29,
    parameter logic [18:0] BASE_ADDR    = 19'h0FF00
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx,
    output logic [18:0] address,
    output logic        write_en,
    output logic [7:0]  data,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    localparam int unsigned TIMER_W = $clog2(CLKS_PER_BIT);
    localparam logic [TIMER_W-1:0] HALF_M1 = TIMER_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TIMER_W-1:0] FULL_M1 = TIMER_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        S_WAIT_MAGIC,
        S_COUNT,
        S_DATA,
        S_CHECK,
        S_DONE
    } ld_state_t;

    logic               rx_meta;
    logic               rx_sync;
    logic               rx_prev;
    rx_state_t          rx_state;
    logic [TIMER_W-1:0] timer;
    logic [2:0]         bit_cnt;
    logic [7:0]         shift;
    logic               byte_valid;
    logic               frame_err;

    ld_state_t          state;
    logic [8:0]         index;
    logic [8:0]         remaining;
    logic [7:0]         sum;

    // UART receiver: two-flop synchroniser, start-bit recheck at half a bit,
    // then one sample per bit period for 8 data bits and the stop bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            rx_state   <= RX_IDLE;
            timer      <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= rx;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    // Edge rather than level, so a line left low after a
                    // framing error does not immediately restart a byte.
                    if (rx_prev && !rx_sync) begin
                        rx_state <= RX_START;
                        timer    <= '0;
                    end
                end
                RX_START: begin
                    if (timer == HALF_M1) begin
                        timer   <= '0;
                        bit_cnt <= '0;
                        // Line back high at mid start bit: treat as a glitch.
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (timer == FULL_M1) begin
                        timer <= '0;
                        shift <= {rx_sync, shift[7:1]};
                        if (bit_cnt == 3'd7) begin
                            rx_state <= RX_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (timer == FULL_M1) begin
                        timer    <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_sync) begin
                            byte_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // Frame parser and bus write generator.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_WAIT_MAGIC;
            index     <= '0;
            remaining <= '0;
            sum       <= '0;
            address   <= '0;
            write_en  <= 1'b0;
            data      <= '0;
            cpu_hold  <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            write_en <= 1'b0;
            if (byte_valid) begin
                case (state)
                    S_WAIT_MAGIC, S_DONE: begin
                        if (shift == 8'hA5) begin
                            state    <= S_COUNT;
                            cpu_hold <= 1'b1;
                            done     <= 1'b0;
                            error    <= 1'b0;
                            index    <= '0;
                            sum      <= '0;
                        end
                    end
                    S_COUNT: begin
                        remaining <= (shift == 8'h00) ? 9'd256 : {1'b0, shift};
                        state     <= S_DATA;
                    end
                    S_DATA: begin
                        write_en  <= 1'b1;
                        address   <= BASE_ADDR + 19'(index);
                        data      <= shift;
                        index     <= index + 9'd1;
                        sum       <= sum + shift;
                        remaining <= remaining - 9'd1;
                        if (remaining == 9'd1) begin
                            state <= S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        if (shift == sum) begin
                            state    <= S_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= S_WAIT_MAGIC;
                            error <= 1'b1;
                        end
                    end
                    default: state <= S_WAIT_MAGIC;
                endcase
            end else if (frame_err) begin
                // Framing errors only matter inside a frame.
                if (state == S_COUNT || state == S_DATA || state == S_CHECK) begin
                    error <= 1'b1;
                    state <= S_WAIT_MAGIC;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_program_loader.sv
// tb_uart_program_loader
// Two loader instances (default base and a base near the top of the address
// space) share clock and reset; a select steers the serial line to one of them.
module tb_uart_program_loader;

    localparam int unsigned CPB    = 4;
    localparam logic [18:0] BASE_A = 19'h0FF00;
    localparam logic [18:0] BASE_B = 19'h7FFFE;

    logic        clock = 1'b0;
    logic        reset;
    logic        line;
    logic        sel;
    logic        rx_a, rx_b;
    logic [18:0] addr_a, addr_b;
    logic        we_a, we_b;
    logic [7:0]  data_a, data_b;
    logic        hold_a, hold_b, done_a, done_b, err_a, err_b;

    assign rx_a = sel ? 1'b1 : line;
    assign rx_b = sel ? line : 1'b1;

    always #5 clock = ~clock;

    uart_program_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(BASE_A)) u_a (
        .clock(clock), .reset(reset), .rx(rx_a), .address(addr_a), .write_en(we_a),
        .data(data_a), .cpu_hold(hold_a), .done(done_a), .error(err_a)
    );

    uart_program_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(BASE_B)) u_b (
        .clock(clock), .reset(reset), .rx(rx_b), .address(addr_b), .write_en(we_b),
        .data(data_b), .cpu_hold(hold_b), .done(done_b), .error(err_b)
    );

    int          total = 0;
    int          bad   = 0;
    logic [26:0] qa[$];
    logic [26:0] qb[$];
    logic        we_prev_a = 1'b0;
    logic        we_prev_b = 1'b0;
    logic [7:0]  fbuf[256];
    logic [7:0]  noise_b[3] = '{8'h00, 8'hFF, 8'h5A};

    typedef struct {
        int          n;
        logic [31:0] d;
        logic [7:0]  xr;
        int          noise;
        logic        glitch;
        logic        ed;
        logic        ee;
        logic        eh;
    } vec_t;

    vec_t vt[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Capture every bus write and confirm strobes are isolated single cycles.
    always @(negedge clock) begin
        if (we_a) begin
            chk("we_a_single", 32'(we_prev_a), 32'd0);
            qa.push_back({addr_a, data_a});
        end
        if (we_b) begin
            chk("we_b_single", 32'(we_prev_b), 32'd0);
            qb.push_back({addr_b, data_b});
        end
        we_prev_a <= we_a;
        we_prev_b <= we_b;
    end

    task automatic send_bit(input logic v);
        line = v;
        repeat (CPB) @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
        send_bit(1'b1);
        send_bit(1'b1);
    endtask

    task automatic send_glitch();
        line = 1'b0;
        @(negedge clock);
        line = 1'b1;
        repeat (10) @(negedge clock);
    endtask

    // Frame from fbuf[0..n-1]; checksum XORed with xr to corrupt it on demand.
    task automatic send_frame(input int n, input logic [7:0] xr);
        int s;
        s = 0;
        send_byte(8'hA5, 1'b1);
        send_byte(8'(n), 1'b1);
        for (int i = 0; i < n; i++) begin
            send_byte(fbuf[i], 1'b1);
            s = s + int'(fbuf[i]);
        end
        send_byte(8'(s % 256) ^ xr, 1'b1);
    endtask

    task automatic check_frame(input string tag, input int s, input logic [18:0] base,
                               input int n, input logic ed, input logic ee, input logic eh);
        int          sz;
        logic [26:0] w;
        logic [18:0] ea;
        logic        d, e, h;
        repeat (4) @(negedge clock);
        sz = (s == 0) ? qa.size() : qb.size();
        chk($sformatf("%s_nwrites", tag), 32'(sz), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (s == 0 && qa.size() > 0) w = qa.pop_front();
            else if (s == 1 && qb.size() > 0) w = qb.pop_front();
            else break;
            ea = 19'((int'(base) + i) % 524288);
            chk($sformatf("%s_addr%0d", tag, i), 32'(w[26:8]), 32'(ea));
            chk($sformatf("%s_data%0d", tag, i), 32'(w[7:0]), 32'(fbuf[i]));
        end
        if (s == 0) qa.delete(); else qb.delete();
        d = (s == 0) ? done_a : done_b;
        e = (s == 0) ? err_a : err_b;
        h = (s == 0) ? hold_a : hold_b;
        chk($sformatf("%s_done", tag), 32'(d), 32'(ed));
        chk($sformatf("%s_error", tag), 32'(e), 32'(ee));
        chk($sformatf("%s_hold", tag), 32'(h), 32'(eh));
        chk($sformatf("%s_excl", tag), 32'(d & e), 32'd0);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_addr_a"}, 32'(addr_a), 32'd0);
        chk({tag, "_we_a"},   32'(we_a),   32'd0);
        chk({tag, "_data_a"}, 32'(data_a), 32'd0);
        chk({tag, "_hold_a"}, 32'(hold_a), 32'd1);
        chk({tag, "_done_a"}, 32'(done_a), 32'd0);
        chk({tag, "_err_a"},  32'(err_a),  32'd0);
        chk({tag, "_addr_b"}, 32'(addr_b), 32'd0);
        chk({tag, "_hold_b"}, 32'(hold_b), 32'd1);
        chk({tag, "_done_b"}, 32'(done_b), 32'd0);
        chk({tag, "_err_b"},  32'(err_b),  32'd0);
    endtask

    function automatic vec_t mk(input int n, input logic [31:0] d, input logic [7:0] xr,
                                input int noise, input logic glitch,
                                input logic ed, input logic ee, input logic eh);
        vec_t v;
        v.n = n; v.d = d; v.xr = xr; v.noise = noise; v.glitch = glitch;
        v.ed = ed; v.ee = ee; v.eh = eh;
        return v;
    endfunction

    initial begin
        int          n;
        int          k;
        logic [7:0]  xr;
        logic [7:0]  nb;

        // d holds data bytes little-end first: d[7:0] is the first data byte.
        vt[0] = mk(3, 32'h00332211, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        vt[1] = mk(1, 32'h00000010, 8'h01, 0, 1'b0, 1'b0, 1'b1, 1'b1);
        vt[2] = mk(1, 32'h00000010, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        vt[3] = mk(1, 32'h00000042, 8'h00, 3, 1'b1, 1'b1, 1'b0, 1'b0);
        vt[4] = mk(2, 32'h0000FFFF, 8'h00, 1, 1'b0, 1'b1, 1'b0, 1'b0);
        vt[5] = mk(4, 32'h04030201, 8'h80, 2, 1'b1, 1'b0, 1'b1, 1'b1);

        sel   = 1'b0;
        line  = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check_reset("por");
        reset = 1'b0;
        repeat (4) @(negedge clock);

        // Table-driven frames on the default-base loader.
        for (int v = 0; v < 6; v++) begin
            if (vt[v].glitch) send_glitch();
            for (int j = 0; j < vt[v].noise; j++) send_byte(noise_b[j], 1'b1);
            for (int i = 0; i < vt[v].n; i++) fbuf[i] = vt[v].d[8*i +: 8];
            send_frame(vt[v].n, vt[v].xr);
            check_frame($sformatf("vec%0d", v), 0, BASE_A, vt[v].n, vt[v].ed, vt[v].ee, vt[v].eh);
        end

        // Framing error on the third data byte of a 4-byte frame.
        fbuf[0] = 8'h01; fbuf[1] = 8'h02;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h04, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b0);
        check_frame("ferr", 0, BASE_A, 2, 1'b0, 1'b1, 1'b1);
        // Back in the magic search: a plain byte must not write.
        send_byte(8'h55, 1'b1);
        check_frame("ferr_idle", 0, BASE_A, 0, 1'b0, 1'b1, 1'b1);

        // Reset in the middle of a frame.
        fbuf[0] = 8'h11; fbuf[1] = 8'h22;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h04, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        check_frame("pre_rst", 0, BASE_A, 2, 1'b0, 1'b0, 1'b1);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check_reset("mid_rst");
        reset = 1'b0;
        repeat (4) @(negedge clock);
        fbuf[0] = 8'h33;
        send_frame(1, 8'h00);
        check_frame("post_rst", 0, BASE_A, 1, 1'b1, 1'b0, 1'b0);

        // Randomised frames: expectations follow directly from how each frame is built.
        for (int r = 0; r < 16; r++) begin
            n  = int'($urandom_range(1, 6));
            xr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            k  = int'($urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1) send_glitch();
            for (int j = 0; j < k; j++) begin
                nb = 8'($urandom_range(0, 255));
                if (nb == 8'hA5) nb = 8'h5A;
                send_byte(nb, 1'b1);
            end
            for (int i = 0; i < n; i++) fbuf[i] = 8'($urandom_range(0, 255));
            send_frame(n, xr);
            check_frame($sformatf("rnd%0d", r), 0, BASE_A, n, (xr == 8'h00),
                        (xr != 8'h00), (xr != 8'h00));
        end

        // Address wrap and 256-byte frame on the high-base loader.
        sel = 1'b1;
        repeat (4) @(negedge clock);
        fbuf[0] = 8'h01; fbuf[1] = 8'h02; fbuf[2] = 8'h03;
        send_frame(3, 8'h00);
        check_frame("wrap", 1, BASE_B, 3, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 256; i++) fbuf[i] = 8'($urandom_range(0, 255));
        send_frame(256, 8'h00);
        check_frame("n256", 1, BASE_B, 256, 1'b1, 1'b0, 1'b0);
        // The idle loader must have seen nothing on its line.
        chk("idle_a_nwrites", 32'(qa.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
